// File: rtl/serial_negate_unit.sv
// Bit-serial negation unit: two's or ones' complement of an operand, LSB first.
// Define SERIAL_NEGATE_OVF_EN to enable detection of the most-negative operand on ovf.
module serial_negate_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] dout_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;

    logic             resultBit;
    logic             carry_d;
    logic [WIDTH-1:0] shreg_d;
    logic             lastBit;

    // Ones' complement is the same datapath with the initial carry forced to 0.
    always_comb begin
        resultBit = ~shreg_q[0] ^ carry_q;
        carry_d   = ~shreg_q[0] & carry_q;
        shreg_d   = {resultBit, shreg_q[WIDTH-1:1]};
        lastBit   = (count_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SHIFT;
                        shreg_q <= din;
                        carry_q <= ~mode;
                        count_q <= '0;
                    end
                end
                SHIFT: begin
                    shreg_q <= shreg_d;
                    carry_q <= carry_d;
                    count_q <= count_q + CW'(1);
                    if (lastBit) begin
                        state_q <= DONE;
                        dout_q  <= shreg_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready      = (state_q == IDLE);
    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign sout_valid = busy;
    assign sout       = busy & resultBit;
    assign dout       = dout_q;

`ifdef SERIAL_NEGATE_OVF_EN
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    logic modeHeld_q;
    logic ovf_q;

    // In two's-complement mode only the most-negative operand maps onto itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            modeHeld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                modeHeld_q <= mode;
            end
            if (state_q == SHIFT && lastBit) begin
                ovf_q <= ~modeHeld_q & (shreg_d == MinNeg);
            end
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/serial_negate_unit.md
SERIAL_NEGATE_UNIT -- requirements
Module: serial_negate_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..64.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port start, input, 1 bit: request to begin an operation; sampled only when ready=1.
REQ-005 Port mode, input, 1 bit: operation select, sampled with start; 0 = two's complement, 1 = ones' complement.
REQ-006 Port din, input, WIDTH bits: operand, sampled with start.
REQ-007 Port ready, output, 1 bit: high when idle and able to accept start.
REQ-008 Port busy, output, 1 bit: high while bits are being shifted.
REQ-009 Port sout, output, 1 bit: current serial result bit, LSB first.
REQ-010 Port sout_valid, output, 1 bit: qualifies sout.
REQ-011 Port done, output, 1 bit: one-cycle pulse when dout is updated.
REQ-012 Port dout, output, WIDTH bits: the last completed result, held until the next completion.
REQ-013 Port ovf, output, 1 bit: overflow flag, held alongside dout.

Function
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 Transition IDLE->SHIFT SHALL occur on an edge with start=1; that edge loads shift register=din, carry=~mode and bit count=0.
REQ-016 In SHIFT, each edge SHALL process bit b=shreg[0] as follows:
  - r = ~b ^ carry;
  - carry <= ~b & carry;
  - shreg shifts right, with r entering at bit WIDTH-1;
  - count increments.
REQ-017 During SHIFT, sout SHALL equal r of the current bit and sout_valid SHALL be 1; otherwise sout_valid=0 and sout=0.
REQ-018 On the edge that processes bit WIDTH-1, the FSM SHALL go SHIFT->DONE and load dout with the full result.
REQ-019 In DONE, done=1 for exactly one cycle; the FSM then SHALL return to IDLE unconditionally.
REQ-020 Latency SHALL be fixed: if start is accepted at edge E0, done SHALL be high in the cycle after edge E0+WIDTH, independent of data and mode.
REQ-021 Output decode SHALL be: ready=1 only in IDLE; busy=1 only in SHIFT.
REQ-022 start SHALL be ignored in SHIFT and DONE, with no queuing; din and mode changes after acceptance SHALL NOT affect the result.
REQ-023 Results:
  - mode=0: dout=(-din) mod 2^WIDTH;
  - mode=1: dout=~din;
  - din=0 in mode 0 SHALL yield 0 with final carry 1, discarded.
REQ-024 dout and ovf SHALL change only on the SHIFT->DONE edge.
REQ-025 Back-to-back operation SHALL be possible: start asserted in the IDLE cycle right after DONE is accepted, giving a period of WIDTH+2 cycles.

Reset
REQ-026 While rst_n=0, the block SHALL hold:
  - state=IDLE, shreg=0, carry=0, count=0;
  - dout=0, ovf=0, done=0, sout=0, sout_valid=0, busy=0;
  - ready=1 immediately.
REQ-027 Reset mid-operation SHALL abort the operation with no done pulse; dout SHALL read 0 afterwards.
REQ-028 Release of rst_n SHALL be sampled so that no state change occurs on the release edge other than normal IDLE start sampling.

Configuration
REQ-029 With macro SERIAL_NEGATE_OVF_EN defined, ovf SHALL be set on the completion edge iff mode=0 and din==2^(WIDTH-1), and cleared on completion otherwise.
REQ-030 Without SERIAL_NEGATE_OVF_EN, port ovf SHALL exist and be tied to 0, with no detection logic synthesised.

Verification (WIDTH=8)
REQ-031 Two's complement: din=0x05, mode=0, start at E0 -> sout 1,1,0,1,1,1,1,1 on E0+1..E0+8; done in the cycle after E0+8; dout=0xFB; ovf=0.
REQ-032 Ones' complement: din=0x05, mode=1 -> dout=0xFA; din=0x00, mode=0 -> dout=0x00; din=0xFF, mode=0 -> dout=0x01.
REQ-033 Overflow: din=0x80, mode=0 -> dout=0x80, with ovf=1 when SERIAL_NEGATE_OVF_EN is defined and ovf=0 without it; the next op din=0x01 -> ovf=0.
REQ-034 Busy protocol: start pulsed with din=0x33 during SHIFT of a 0x05 operation -> ignored; only one done; dout=0xFB.
REQ-035 Reset abort: rst_n low at E0+4 of an operation -> done never pulses; dout=0 and ready=1 asynchronously; the next op din=0x01 -> dout=0xFF.
REQ-036 Back-to-back and width: start held high continuously gives done every 10 cycles; rerun with WIDTH=2 and WIDTH=16, din=1 -> dout all-ones.
